// File: rtl/pipe_trace_pkg.sv
// Shared types and constants for the pipeline trace unit.
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } trace_state_e;

    localparam logic [2:0] CNT_SEL_CYCLE  = 3'd0;
    localparam logic [2:0] CNT_SEL_STALL  = 3'd1;
    localparam logic [2:0] CNT_SEL_FLUSH  = 3'd2;
    localparam logic [2:0] CNT_SEL_RETIRE = 3'd3;
    localparam logic [2:0] CNT_SEL_DROP   = 3'd4;

    localparam int unsigned PC_W = 32;

    // Cycle index width is a top-level parameter, so the record adds it around this part.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            stall;
        logic            flush;
    } trace_info_t;

endpackage

// File: rtl/pipe_trace_unit_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module trace_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

    // A pop frees the head slot this cycle, so a full FIFO can still accept.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/pipe_trace_unit.sv
// Pipeline trace unit: per-cycle trace records, saturating statistics and a cycle budget halt.
module pipe_trace_unit
    import pipe_trace_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 70,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      pc_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             retire_i,
    output logic             tr_valid_o,
    input  logic             tr_ready_i,
    output logic [CNT_W-1:0] tr_cycle_o,
    output logic [31:0]      tr_pc_o,
    output logic             tr_stall_o,
    output logic             tr_flush_o,
    input  logic [2:0]       cnt_sel_i,
    output logic [CNT_W-1:0] cnt_data_o,
    output logic             halt_o
);

    typedef struct packed {
        logic [CNT_W-1:0] cycle;
        trace_info_t      info;
    } trace_rec_t;

    localparam int unsigned RecW = $bits(trace_rec_t);
    localparam logic [CNT_W+31:0] LastCycle = (CNT_W+32)'(MAX_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    trace_state_e     state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
    logic             halt_q;

    trace_rec_t push_rec;
    trace_rec_t head_rec;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       budget_hit;

    assign push       = (state_q == StRun);
    assign tr_valid_o = !fifo_empty;
    assign pop        = tr_valid_o && tr_ready_i;
    assign budget_hit = (MAX_CYCLES != 0) && ({32'd0, cycle_q} == LastCycle);

    always_comb begin
        push_rec            = '0;
        push_rec.cycle      = cycle_q;
        push_rec.info.pc    = pc_i;
        push_rec.info.stall = stall_i;
        push_rec.info.flush = flush_i;
    end

    trace_fifo #(
        .Width (RecW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (push_rec),
        .pop_i   (pop),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        retire_d = retire_q;
        drop_d   = drop_q;
        case (state_q)
            StIdle: begin
                if (start_i) state_d = StRun;
            end
            StRun: begin
                cycle_d = sat_inc(cycle_q);
                if (stall_i)  stall_d  = sat_inc(stall_q);
                if (flush_i)  flush_d  = sat_inc(flush_q);
                if (retire_i) retire_d = sat_inc(retire_q);
                // Budget expiry wins over start_i dropping in the same cycle.
                if (budget_hit)    state_d = StHalted;
                else if (!start_i) state_d = StIdle;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
        if (push && fifo_full && !pop) drop_d = sat_inc(drop_q);
    end

    always_comb begin
        cnt_data_d = '0;
        case (cnt_sel_i)
            CNT_SEL_CYCLE:  cnt_data_d = cycle_q;
            CNT_SEL_STALL:  cnt_data_d = stall_q;
            CNT_SEL_FLUSH:  cnt_data_d = flush_q;
            CNT_SEL_RETIRE: cnt_data_d = retire_q;
            CNT_SEL_DROP:   cnt_data_d = drop_q;
            default:        cnt_data_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cycle_q    <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            retire_q   <= '0;
            drop_q     <= '0;
            cnt_data_q <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            retire_q   <= retire_d;
            drop_q     <= drop_d;
            cnt_data_q <= cnt_data_d;
            halt_q     <= (state_d == StHalted);
        end
    end

    assign tr_cycle_o = head_rec.cycle;
    assign tr_pc_o    = head_rec.info.pc;
    assign tr_stall_o = head_rec.info.stall;
    assign tr_flush_o = head_rec.info.flush;
    assign cnt_data_o = cnt_data_q;
    assign halt_o     = halt_q;

endmodule
